// File: rtl/game_ctrl_pkg.sv
// rtl/game_ctrl_pkg.sv - state encoding, defaults and strobe decode for game_control
// Contents: state_t (S_INIT..S_DRAW_CHAR), DEFAULT_FRAME_DIV, DEFAULT_CNT_W,
//           strobe_decode() mapping a state to its one-hot phase strobe vector.
package game_ctrl_pkg;

    localparam int DEFAULT_FRAME_DIV = 833333;  // 50 MHz / 60 Hz
    localparam int DEFAULT_CNT_W     = 20;

    typedef enum logic [2:0] {
        S_INIT      = 3'd0,
        S_IDLE      = 3'd1,
        S_REG       = 3'd2,
        S_CHECK     = 3'd3,
        S_APPLY     = 3'd4,
        S_DRAW_MAP  = 3'd5,
        S_DRAW_CHAR = 3'd6
    } state_t;

    // Bit n of the result is the strobe for the state encoded as n.
    function automatic logic [6:0] strobe_decode(input state_t s);
        return 7'b000_0001 << s;
    endfunction

endpackage

// File: rtl/game_control_if.sv
// rtl/game_control_if.sv - phase strobe / done handshake bundle between game_control and its clients
// master: game_control (drives strobes, status; samples done levels)
// slave : character / collision / map blocks (drive done levels; consume strobes)
interface game_control_if;
    logic       collide_done;
    logic       map_done;
    logic       char_done;
    logic       init;
    logic       idle;
    logic       reg_action;
    logic       check_collision;
    logic       apply_action;
    logic       draw_map;
    logic       draw_char;
    logic       frame_overrun;
    logic       wd_error;
    logic [2:0] state_dbg;

    modport master (
        input  collide_done, map_done, char_done,
        output init, idle, reg_action, check_collision, apply_action,
               draw_map, draw_char, frame_overrun, wd_error, state_dbg
    );

    modport slave (
        output collide_done, map_done, char_done,
        input  init, idle, reg_action, check_collision, apply_action,
               draw_map, draw_char, frame_overrun, wd_error, state_dbg
    );
endinterface

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - free-running frame divider producing a one-cycle tick per frame
// Ports: clock, reset (sync, active-high), tick (high while count == FRAME_DIV-1).
module frame_tick_gen #(
    parameter int FRAME_DIV = 833333,
    parameter int CNT_W     = 20
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(FRAME_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/game_control.sv
// rtl/game_control.sv - game loop sequencer: frame pacing, phase strobes, overrun and watchdog flags
// Ports: clock, reset (sync, active-high), bus (game_control_if.master: done levels in,
//        one-hot phase strobes, frame_overrun, wd_error, state_dbg out).
// Optional: define GAME_CTRL_WATCHDOG_EN to build the wait-state watchdog (limit WD_LIMIT).
module game_control
    import game_ctrl_pkg::*;
#(
    parameter int          FRAME_DIV = DEFAULT_FRAME_DIV,
    parameter int          CNT_W     = DEFAULT_CNT_W,
    parameter logic [15:0] WD_LIMIT  = 16'd65535
) (
    input  logic          clock,
    input  logic          reset,
    game_control_if.master bus
);

    state_t     state;
    state_t     state_n;
    logic [6:0] strobe_q;
    logic       pending;
    logic       overrun;
    logic       tick;

    frame_tick_gen #(
        .FRAME_DIV (FRAME_DIV),
        .CNT_W     (CNT_W)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

`ifdef GAME_CTRL_WATCHDOG_EN
    logic [15:0] wd_cnt;
    logic        wd_err;
    logic        in_wait;
    logic        wd_expire;

    assign in_wait   = (state == S_CHECK) || (state == S_DRAW_MAP) || (state == S_DRAW_CHAR);
    // Fires on the last permitted cycle so the wait state lasts exactly WD_LIMIT cycles.
    assign wd_expire = in_wait && (wd_cnt == WD_LIMIT - 16'd1);
`endif

    always_comb begin
        state_n = state;
        case (state)
            S_INIT:      state_n = S_IDLE;
            S_IDLE:      if (pending || tick) state_n = S_REG;
            S_REG:       state_n = S_CHECK;
            S_CHECK:     if (bus.collide_done) state_n = S_APPLY;
            S_APPLY:     state_n = S_DRAW_MAP;
            S_DRAW_MAP:  if (bus.map_done) state_n = S_DRAW_CHAR;
            S_DRAW_CHAR: if (bus.char_done) state_n = S_IDLE;
            default:     state_n = S_INIT;
        endcase
`ifdef GAME_CTRL_WATCHDOG_EN
        if (wd_expire) state_n = S_IDLE;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_INIT;
            strobe_q <= strobe_decode(S_INIT);
            pending  <= 1'b0;
            overrun  <= 1'b0;
`ifdef GAME_CTRL_WATCHDOG_EN
            wd_cnt   <= 16'd0;
            wd_err   <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            // Strobes are registered from the next state so they line up with state.
            strobe_q <= strobe_decode(state_n);

            // A tick outside S_IDLE is remembered; a second one before it is consumed is lost.
            if (tick && (state != S_IDLE)) begin
                pending <= 1'b1;
                if (pending) overrun <= 1'b1;
            end else if ((state == S_IDLE) && (state_n == S_REG)) begin
                pending <= 1'b0;
            end

`ifdef GAME_CTRL_WATCHDOG_EN
            if (state_n != state) begin
                wd_cnt <= 16'd0;
            end else if (in_wait) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
            if (wd_expire) wd_err <= 1'b1;
`endif
        end
    end

    assign bus.init            = strobe_q[0];
    assign bus.idle            = strobe_q[1];
    assign bus.reg_action      = strobe_q[2];
    assign bus.check_collision = strobe_q[3];
    assign bus.apply_action    = strobe_q[4];
    assign bus.draw_map        = strobe_q[5];
    assign bus.draw_char       = strobe_q[6];
    assign bus.frame_overrun   = overrun;
    assign bus.state_dbg       = state;

`ifdef GAME_CTRL_WATCHDOG_EN
    assign bus.wd_error = wd_err;
`else
    assign bus.wd_error = 1'b0;
    wire unused_wd_limit = ^WD_LIMIT;
`endif

endmodule

// File: tb/tb_game_control.sv
// tb/tb_game_control.sv - directed self-checking bench for game_control (FRAME_DIV=32, WD_LIMIT=100)
module tb_game_control;

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_REG   = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_APPLY = 3'd4;
    localparam logic [2:0] ST_MAP   = 3'd5;
    localparam logic [2:0] ST_CHAR  = 3'd6;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   onehot_err = 0;
    bit   mon_en = 1'b0;
    int   n;

    game_control_if bus();

    game_control #(
        .FRAME_DIV (32),
        .CNT_W     (5),
        .WD_LIMIT  (16'd100)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    wire [6:0] strobes = {bus.draw_char, bus.draw_map, bus.apply_action, bus.check_collision,
                          bus.reg_action, bus.idle, bus.init};

    always @(negedge clock) begin
        if (mon_en && !$onehot(strobes)) onehot_err++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed still running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_done(input int which, input logic v);
        case (which)
            0:       bus.collide_done = v;
            1:       bus.map_done     = v;
            default: bus.char_done    = v;
        endcase
    endtask

    // Negedges until state_dbg == s (bounded).
    task automatic wait_state(input logic [2:0] s, input int limit, output int cnt);
        cnt = 0;
        while (bus.state_dbg !== s && cnt < limit) begin
            @(negedge clock);
            cnt++;
        end
    endtask

    // Cycles spent in state s starting from the current negedge (bounded).
    task automatic dwell(input logic [2:0] s, input int limit, output int cnt);
        cnt = 0;
        while (bus.state_dbg === s && cnt < limit) begin
            cnt++;
            @(negedge clock);
        end
    endtask

    // Stay in wait state s, raising the selected done in its hold-th cycle.
    task automatic phase(input logic [2:0] s, input int hold, input int which, output int cnt);
        cnt = 0;
        while (bus.state_dbg === s && cnt < hold) begin
            cnt++;
            if (cnt == hold) set_done(which, 1'b1);
            @(negedge clock);
        end
        set_done(which, 1'b0);
    endtask

    initial begin
        bus.collide_done = 1'b0;
        bus.map_done     = 1'b0;
        bus.char_done    = 1'b0;

        // Reset and first frame
        repeat (3) @(negedge clock);
        mon_en = 1'b1;
        chk("rst_init", bus.init, 1);
        chk("rst_state", bus.state_dbg, ST_INIT);
        chk("rst_overrun", bus.frame_overrun, 0);
        chk("rst_wd_error", bus.wd_error, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("init_one_cycle", bus.init, 0);
        chk("idle_after_init", bus.idle, 1);
        wait_state(ST_REG, 100, n);
        chk("first_reg_latency", n, 31);
        chk("first_reg_strobe", bus.reg_action, 1);

`ifndef GAME_CTRL_WATCHDOG_EN
        // Full frame with long draw phases
        @(negedge clock);
        chk("reg_one_cycle", bus.state_dbg, ST_CHECK);
        phase(ST_CHECK, 5, 0, n);
        chk("check_len", n, 5);
        chk("apply_strobe", bus.apply_action, 1);
        @(negedge clock);
        phase(ST_MAP, 11, 1, n);
        chk("map_len", n, 11);
        chk("char_strobe", bus.draw_char, 1);
        phase(ST_CHAR, 257, 2, n);
        chk("char_len", n, 257);
        chk("idle_after_frame", bus.idle, 1);
        chk("long_frame_overrun", bus.frame_overrun, 1);
        chk("wd_error_tied", bus.wd_error, 0);
        @(negedge clock);
        chk("pending_restart", bus.state_dbg, ST_REG);

        // char_done held high: no double frame
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        bus.char_done = 1'b1;
        wait_state(ST_REG, 100, n);
        chk("held_reg_latency", n, 32);
        @(negedge clock);
        phase(ST_CHECK, 1, 0, n);
        @(negedge clock);
        phase(ST_MAP, 1, 1, n);
        dwell(ST_CHAR, 10, n);
        chk("held_char_len", n, 1);
        dwell(ST_IDLE, 100, n);
        chk("held_idle_len", n, 27);
        chk("held_next_reg", bus.state_dbg, ST_REG);
        chk("held_no_overrun", bus.frame_overrun, 0);
        bus.char_done = 1'b0;

        // map_done withheld: pending, then overrun
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        wait_state(ST_REG, 100, n);
        @(negedge clock);
        phase(ST_CHECK, 1, 0, n);
        @(negedge clock);
        phase(ST_MAP, 40, 1, n);
        chk("map40_len", n, 40);
        chk("map40_no_overrun", bus.frame_overrun, 0);
        phase(ST_CHAR, 1, 2, n);
        dwell(ST_IDLE, 100, n);
        chk("map40_idle_len", n, 1);
        @(negedge clock);
        phase(ST_CHECK, 1, 0, n);
        @(negedge clock);
        phase(ST_MAP, 70, 1, n);
        chk("map70_len", n, 70);
        chk("map70_overrun", bus.frame_overrun, 1);
        phase(ST_CHAR, 1, 2, n);
        dwell(ST_IDLE, 100, n);
        chk("map70_idle_len", n, 1);

        // Reset while in S_DRAW_MAP
        @(negedge clock);
        phase(ST_CHECK, 1, 0, n);
        @(negedge clock);
        chk("in_draw_map", bus.state_dbg, ST_MAP);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_state", bus.state_dbg, ST_INIT);
        chk("midrst_init", bus.init, 1);
        chk("midrst_overrun", bus.frame_overrun, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_idle", bus.idle, 1);
        wait_state(ST_REG, 100, n);
        chk("midrst_reg_latency", n, 31);
`else
        // Watchdog: collide_done never arrives
        @(negedge clock);
        dwell(ST_CHECK, 200, n);
        chk("wd_check_len", n, 100);
        chk("wd_idle", bus.idle, 1);
        chk("wd_error_set", bus.wd_error, 1);
        dwell(ST_IDLE, 100, n);
        chk("wd_restart_idle_len", n, 1);
        chk("wd_restart_reg", bus.state_dbg, ST_REG);
        chk("wd_error_sticky", bus.wd_error, 1);
`endif

        chk("onehot_strobes", onehot_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/game_control.md
Name: game_control

Overview:
- Top-level sequencing FSM that sits directly upstream of the character logic.
- Drives the per-frame phase strobes consumed by the character block: init, idle, reg_action, apply_action, draw_char.
- Also drives the collision detector start (check_collision) and the map drawer enable (draw_map).
- Paces the whole game loop from an internal frame-tick divider and advances phases on done handshakes.

Parameters:
- FRAME_DIV, 833333, clock cycles per game frame (50 MHz / 60 Hz); legal range 16..2^CNT_W.
- CNT_W, 20, width of frame divider counter.
- WD_LIMIT, 16'd65535, watchdog cycle limit per wait state (used only with the optional feature).

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- collide_done  in  1  collision detector result valid; level, sampled only in S_CHECK.
- map_done  in  1  map drawer finished; level, sampled only in S_DRAW_MAP.
- char_done  in  1  character draw_done; level, sampled only in S_DRAW_CHAR.
- init  out  1  high in S_INIT.
- idle  out  1  high in S_IDLE.
- reg_action  out  1  high in S_REG.
- check_collision  out  1  high in S_CHECK.
- apply_action  out  1  high in S_APPLY.
- draw_map  out  1  high in S_DRAW_MAP.
- draw_char  out  1  high in S_DRAW_CHAR.
- frame_overrun  out  1  sticky: a frame tick was lost.
- wd_error  out  1  sticky watchdog flag; tied 0 when the optional feature is disabled.
- state_dbg  out  3  current state encoding.

Behaviour:
- Clocking and reset: one clock, `clock`; `reset` is synchronous and active-high.
- Outputs: strobes are a one-hot Moore decode of the registered state; exactly one strobe is high in every cycle.
- Reset: reset sampled high sets state=S_INIT, frame counter=0, pending=0, frame_overrun=0, wd_error=0.
  - Outputs after that edge: init=1, all other strobes 0, state_dbg=0.
  - Reset mid-operation aborts any phase immediately; no done is awaited.
- State encoding: S_INIT=0, S_IDLE=1, S_REG=2, S_CHECK=3, S_APPLY=4, S_DRAW_MAP=5, S_DRAW_CHAR=6; code 7 is illegal and goes to S_INIT.
- Transitions:
  - S_INIT -> S_IDLE unconditionally (init lasts exactly 1 cycle after reset release).
  - S_IDLE -> S_REG when (pending | tick); otherwise stay.
  - S_REG -> S_CHECK unconditionally (1 cycle).
  - S_CHECK -> S_APPLY when collide_done=1; otherwise hold.
  - S_APPLY -> S_DRAW_MAP unconditionally (1 cycle).
  - S_DRAW_MAP -> S_DRAW_CHAR when map_done=1.
  - S_DRAW_CHAR -> S_IDLE when char_done=1.
- S_IDLE always lasts ≥1 cycle. This lets the character block clear its level draw_done, so a stale char_done is never seen on the next frame.
- Frame divider:
  - Counter runs freely in all states and counts 0..FRAME_DIV-1, then wraps to 0.
  - tick=1 in the cycle count==FRAME_DIV-1.
- Pending and overrun:
  - pending is set by tick when not in S_IDLE; cleared on the S_IDLE->S_REG transition.
  - A tick in S_IDLE is consumed directly and does not set pending.
  - A tick while pending=1 and state!=S_IDLE sets frame_overrun=1; the flag is cleared only by reset. A pending count never exceeds 1.
- Latency: tick at cycle T in S_IDLE -> reg_action at T+1 -> check_collision at T+2 -> apply_action on the cycle after collide_done is sampled high.
- Done inputs asserted outside their own wait state are ignored.

Optional Feature:
- Macro: GAME_CTRL_WATCHDOG_EN.
- When defined:
  - A 16-bit counter clears on every state change and increments each cycle spent in S_CHECK, S_DRAW_MAP or S_DRAW_CHAR.
  - Reaching WD_LIMIT forces next state S_IDLE and sets sticky wd_error=1; only reset clears it.
- When undefined: no counter is built, wait states hold indefinitely, and wd_error=0 constantly.

Decomposition:
- Package game_ctrl_pkg holds the state encoding constants (S_INIT..S_DRAW_CHAR) and the default FRAME_DIV.
- Sub-module frame_tick_gen (parameters FRAME_DIV, CNT_W; ports clock, reset, tick) holds the divider.
- FSM, pending/overrun and watchdog logic stay in game_control.

Test Plan:
- FRAME_DIV=32; reset 3 cycles, release -> init=1 for exactly 1 cycle, then idle=1; first reg_action 32 cycles after reset release.
- Full frame: collide_done 4 cycles after check_collision, map_done after 10 cycles, char_done after 256 cycles -> strobe sequence REG(1), CHECK(5), APPLY(1), DRAW_MAP(11), DRAW_CHAR(257), then IDLE; each strobe one-hot.
- Hold char_done high continuously -> S_DRAW_CHAR lasts 1 cycle, S_IDLE lasts ≥1 cycle, no double frame without a tick; frame_overrun=0.
- FRAME_DIV=32, map_done withheld 40 cycles -> pending set, no overrun; withheld 70 cycles -> frame_overrun=1; after completion the next frame starts 1 cycle into S_IDLE.
- Reset asserted in S_DRAW_MAP -> next cycle state_dbg=0, init=1, frame_overrun cleared, counter restarts.
- With GAME_CTRL_WATCHDOG_EN and WD_LIMIT=100, collide_done never asserted -> after 100 cycles in S_CHECK: idle=1, wd_error=1, and next tick restarts the frame.
